wb_ctrl: RTL and testbench

WB_CTRL -- requirements
Module: wb_ctrl

---
 rtl/wb_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_wb_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_ctrl.sv
// ---------------------------------------------------------------------------
// wb_ctrl -- write-back controller for a simple in-order pipeline.
//
// Merges two result sources onto a single register-file write port:
//   * single-cycle ALU results, buffered through a one-entry skid buffer
//   * load responses, returned in issue order and paired with the
//     destination register held in an in-order tag FIFO
// Load responses always win the write port. An ALU result that loses to a
// load response is parked in the skid buffer and written on a later cycle.
// The block also reports, for the instruction in decode, whether rs1/rs2
// name a register that still has a write in flight (stall).
//
// Parameters:
//   LQ_DEPTH        outstanding-load tag entries (power of two, 2..16)
//
// Optional feature (compile-time macro):
//   WB_CTRL_BYPASS_EN  when defined, a match against the registered write
//                      stage is forwarded (rsN_fwd_*) instead of stalling.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   alu_valid/rd/data, alu_ready            ALU result input
//   ld_issue_valid/rd, ld_issue_ready       load issue (reserves rd)
//   ld_resp_valid/data                      in-order load data
//   rf_we_n, rf_rd, rf_wd                   register-file write port
//   rs1, rs2, stall                         decode hazard check
//   rs1/rs2_fwd_valid, rs1/rs2_fwd_data     write-stage forwarding
//   resp_err                    sticky: response arrived with no load queued
// ---------------------------------------------------------------------------
module wb_ctrl #(
  parameter int LQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        ld_issue_valid,
  input  logic [4:0]  ld_issue_rd,
  output logic        ld_issue_ready,
  input  logic        ld_resp_valid,
  input  logic [31:0] ld_resp_data,
  output logic        rf_we_n,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        stall,
  output logic        rs1_fwd_valid,
  output logic [31:0] rs1_fwd_data,
  output logic        rs2_fwd_valid,
  output logic [31:0] rs2_fwd_data,
  output logic        resp_err
);

  localparam int PW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int CW = PW + 1;

  // Tag FIFO state
  logic [4:0]    tag_q [LQ_DEPTH];
  logic [4:0]    tag_d [LQ_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Skid buffer, error flag and registered write stage
  logic          skid_valid_q, skid_valid_d;
  logic [4:0]    skid_rd_q, skid_rd_d;
  logic [31:0]   skid_data_q, skid_data_d;
  logic          resp_err_q, resp_err_d;
  logic          rf_we_n_q, rf_we_n_d;
  logic [4:0]    rf_rd_q, rf_rd_d;
  logic [31:0]   rf_wd_q, rf_wd_d;

  // Handshake / selection helpers
  logic          fifo_full_s, fifo_empty_s;
  logic          push_s, pop_s, alu_acc_s;
  logic          sel_valid_s;
  logic [4:0]    sel_rd_s;
  logic [31:0]   sel_data_s;
  logic          rs1_fifo_hit_s, rs2_fifo_hit_s;
  logic          rs1_wr_hit_s, rs2_wr_hit_s;
  logic          rs1_pend_s, rs2_pend_s;

  // FIFO status and handshakes. A full FIFO refuses a push even if a pop
  // frees a slot in the same cycle, keeping ld_issue_ready purely registered.
  always_comb begin
    fifo_full_s  = (cnt_q == CW'(LQ_DEPTH));
    fifo_empty_s = (cnt_q == {CW{1'b0}});
    push_s       = ld_issue_valid && !fifo_full_s;
    pop_s        = ld_resp_valid && !fifo_empty_s;
    alu_acc_s    = alu_valid && !skid_valid_q;
  end

  // Tag FIFO next state. Loads to x0 are queued too so that their
  // responses still pop in order; x0 never matches as pending.
  always_comb begin
    tag_d = tag_q;
    if (push_s) begin
      tag_d[wr_ptr_q] = ld_issue_rd;
    end else begin
      tag_d = tag_q;
    end
    wr_ptr_d = push_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    resp_err_d = resp_err_q | (ld_resp_valid & fifo_empty_s);
  end

  // Write-source arbitration: load response > skid entry > ALU input.
  // An ALU result accepted while a load wins is parked in the skid buffer.
  always_comb begin
    sel_valid_s  = 1'b0;
    sel_rd_s     = 5'd0;
    sel_data_s   = 32'd0;
    skid_valid_d = skid_valid_q;
    skid_rd_d    = skid_rd_q;
    skid_data_d  = skid_data_q;
    if (pop_s) begin
      sel_valid_s = 1'b1;
      sel_rd_s    = tag_q[rd_ptr_q];
      sel_data_s  = ld_resp_data;
      if (alu_acc_s) begin
        skid_valid_d = 1'b1;
        skid_rd_d    = alu_rd;
        skid_data_d  = alu_data;
      end else begin
        skid_valid_d = skid_valid_q;
      end
    end else if (skid_valid_q) begin
      sel_valid_s  = 1'b1;
      sel_rd_s     = skid_rd_q;
      sel_data_s   = skid_data_q;
      skid_valid_d = 1'b0;
    end else if (alu_acc_s) begin
      sel_valid_s = 1'b1;
      sel_rd_s    = alu_rd;
      sel_data_s  = alu_data;
    end else begin
      sel_valid_s = 1'b0;
    end
    rf_we_n_d = !(sel_valid_s && (sel_rd_s != 5'd0));
    rf_rd_d   = sel_valid_s ? sel_rd_s : 5'd0;
    rf_wd_d   = sel_valid_s ? sel_data_s : 32'd0;
  end

  // Search the live FIFO entries (head .. head+cnt-1) for rs1/rs2.
  always_comb begin
    rs1_fifo_hit_s = 1'b0;
    rs2_fifo_hit_s = 1'b0;
    for (int k = 0; k < LQ_DEPTH; k++) begin
      rs1_fifo_hit_s = rs1_fifo_hit_s |
        ((CW'(k) < cnt_q) && (tag_q[PW'(rd_ptr_q + PW'(k))] == rs1));
      rs2_fifo_hit_s = rs2_fifo_hit_s |
        ((CW'(k) < cnt_q) && (tag_q[PW'(rd_ptr_q + PW'(k))] == rs2));
    end
  end

  // Hazard and forwarding outputs. With bypass, the write stage feeds the
  // decode operands directly and therefore no longer counts as pending.
  always_comb begin
`ifdef WB_CTRL_BYPASS_EN
    rs1_wr_hit_s  = 1'b0;
    rs2_wr_hit_s  = 1'b0;
    rs1_fwd_valid = (rs1 != 5'd0) && !rf_we_n_q && (rf_rd_q == rs1);
    rs2_fwd_valid = (rs2 != 5'd0) && !rf_we_n_q && (rf_rd_q == rs2);
    rs1_fwd_data  = rs1_fwd_valid ? rf_wd_q : 32'd0;
    rs2_fwd_data  = rs2_fwd_valid ? rf_wd_q : 32'd0;
`else
    rs1_wr_hit_s  = !rf_we_n_q && (rf_rd_q == rs1);
    rs2_wr_hit_s  = !rf_we_n_q && (rf_rd_q == rs2);
    rs1_fwd_valid = 1'b0;
    rs2_fwd_valid = 1'b0;
    rs1_fwd_data  = 32'd0;
    rs2_fwd_data  = 32'd0;
`endif
    rs1_pend_s = (rs1 != 5'd0) && (rs1_fifo_hit_s ||
                 (skid_valid_q && (skid_rd_q == rs1)) || rs1_wr_hit_s);
    rs2_pend_s = (rs2 != 5'd0) && (rs2_fifo_hit_s ||
                 (skid_valid_q && (skid_rd_q == rs2)) || rs2_wr_hit_s);
    stall      = rs1_pend_s || rs2_pend_s;
  end

  // Output ports driven from registers.
  always_comb begin
    alu_ready      = !skid_valid_q;
    ld_issue_ready = !fifo_full_s;
    rf_we_n        = rf_we_n_q;
    rf_rd          = rf_rd_q;
    rf_wd          = rf_wd_q;
    resp_err       = resp_err_q;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LQ_DEPTH; i++) begin
        tag_q[i] <= 5'd0;
      end
      rd_ptr_q     <= {PW{1'b0}};
      wr_ptr_q     <= {PW{1'b0}};
      cnt_q        <= {CW{1'b0}};
      skid_valid_q <= 1'b0;
      skid_rd_q    <= 5'd0;
      skid_data_q  <= 32'd0;
      resp_err_q   <= 1'b0;
      rf_we_n_q    <= 1'b1;
      rf_rd_q      <= 5'd0;
      rf_wd_q      <= 32'd0;
    end else begin
      tag_q        <= tag_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      skid_valid_q <= skid_valid_d;
      skid_rd_q    <= skid_rd_d;
      skid_data_q  <= skid_data_d;
      resp_err_q   <= resp_err_d;
      rf_we_n_q    <= rf_we_n_d;
      rf_rd_q      <= rf_rd_d;
      rf_wd_q      <= rf_wd_d;
    end
  end

endmodule

// File: tb/tb_wb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_wb_ctrl -- directed self-checking bench for wb_ctrl (LQ_DEPTH = 4).
// Inputs change 1 time unit after the rising edge; outputs are checked
// after a further settle delay, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        ld_issue_valid;
  logic [4:0]  ld_issue_rd;
  logic        ld_issue_ready;
  logic        ld_resp_valid;
  logic [31:0] ld_resp_data;
  logic        rf_we_n;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        stall;
  logic        rs1_fwd_valid;
  logic [31:0] rs1_fwd_data;
  logic        rs2_fwd_valid;
  logic [31:0] rs2_fwd_data;
  logic        resp_err;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  wb_ctrl #(.LQ_DEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .alu_valid      (alu_valid),
    .alu_rd         (alu_rd),
    .alu_data       (alu_data),
    .alu_ready      (alu_ready),
    .ld_issue_valid (ld_issue_valid),
    .ld_issue_rd    (ld_issue_rd),
    .ld_issue_ready (ld_issue_ready),
    .ld_resp_valid  (ld_resp_valid),
    .ld_resp_data   (ld_resp_data),
    .rf_we_n        (rf_we_n),
    .rf_rd          (rf_rd),
    .rf_wd          (rf_wd),
    .rs1            (rs1),
    .rs2            (rs2),
    .stall          (stall),
    .rs1_fwd_valid  (rs1_fwd_valid),
    .rs1_fwd_data   (rs1_fwd_data),
    .rs2_fwd_valid  (rs2_fwd_valid),
    .rs2_fwd_data   (rs2_fwd_data),
    .resp_err       (resp_err)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    ld_issue_valid = 1'b0; ld_issue_rd = 5'd0;
    ld_resp_valid = 1'b0; ld_resp_data = 32'd0; rs1 = 5'd0; rs2 = 5'd0;

    // Reset state
    cyc(); cyc();
    rst_n = 1'b1;
    #1;
    chk1 ("rst_we_n",      rf_we_n, 1'b1);
    chk32("rst_rd",        32'(rf_rd), 32'd0);
    chk32("rst_wd",        rf_wd, 32'd0);
    chk1 ("rst_alu_rdy",   alu_ready, 1'b1);
    chk1 ("rst_ld_rdy",    ld_issue_ready, 1'b1);
    chk1 ("rst_stall",     stall, 1'b0);
    chk1 ("rst_resp_err",  resp_err, 1'b0);
    chk1 ("rst_fwd1",      rs1_fwd_valid, 1'b0);
    chk1 ("rst_fwd2",      rs2_fwd_valid, 1'b0);

    // ALU x5 = 0x1234, one-cycle write
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h0000_1234;
    cyc();
    alu_valid = 1'b0;
    #1;
    chk1 ("alu_we_n",  rf_we_n, 1'b0);
    chk32("alu_rd",    32'(rf_rd), 32'd5);
    chk32("alu_wd",    rf_wd, 32'h0000_1234);
    cyc();
    chk1 ("alu_we_n_once", rf_we_n, 1'b1);

    // Fill the tag FIFO with x1..x4
    for (int i = 1; i <= 4; i++) begin
      ld_issue_valid = 1'b1; ld_issue_rd = 5'(i);
      cyc();
    end
    ld_issue_valid = 1'b0;
    #1;
    chk1 ("full_ready", ld_issue_ready, 1'b0);
    rs1 = 5'd3;
    #1;
    chk1 ("full_stall_x3", stall, 1'b1);
    rs1 = 5'd0;
    // Response while full plus an issue attempt of x10 that must be refused
    ld_resp_valid = 1'b1; ld_resp_data = 32'h0000_00AA;
    ld_issue_valid = 1'b1; ld_issue_rd = 5'd10;
    #1;
    chk1 ("full_ready_pop", ld_issue_ready, 1'b0);
    cyc();
    ld_resp_valid = 1'b0; ld_issue_valid = 1'b0;
    #1;
    chk1 ("ld_x1_we_n", rf_we_n, 1'b0);
    chk32("ld_x1_rd",   32'(rf_rd), 32'd1);
    chk32("ld_x1_wd",   rf_wd, 32'h0000_00AA);
    chk1 ("ld_rdy_back", ld_issue_ready, 1'b1);
    rs1 = 5'd10;
    #1;
    chk1 ("no_push_full", stall, 1'b0);
    rs1 = 5'd0;
    // Drain x2..x4 in order
    for (int i = 2; i <= 4; i++) begin
      ld_resp_valid = 1'b1; ld_resp_data = 32'h0000_0100 + 32'(i);
      cyc();
      ld_resp_valid = 1'b0;
      #1;
      chk32("drain_rd", 32'(rf_rd), 32'(i));
      chk32("drain_wd", rf_wd, 32'h0000_0100 + 32'(i));
    end
    cyc();
    chk1 ("drain_idle", rf_we_n, 1'b1);

    // Load x7 response collides with ALU x8
    ld_issue_valid = 1'b1; ld_issue_rd = 5'd7;
    cyc();
    ld_issue_valid = 1'b0;
    ld_resp_valid = 1'b1; ld_resp_data = 32'h0000_00BB;
    alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'h0000_00CC;
    #1;
    chk1 ("col_alu_rdy_T", alu_ready, 1'b1);
    cyc();
    ld_resp_valid = 1'b0; alu_valid = 1'b0; rs2 = 5'd8;
    #1;
    chk1 ("col_t1_we_n",  rf_we_n, 1'b0);
    chk32("col_t1_rd",    32'(rf_rd), 32'd7);
    chk32("col_t1_wd",    rf_wd, 32'h0000_00BB);
    chk1 ("col_t1_alurdy", alu_ready, 1'b0);
    chk1 ("col_t1_skid_stall", stall, 1'b1);
    rs2 = 5'd0;
    cyc();
    chk1 ("col_t2_we_n",  rf_we_n, 1'b0);
    chk32("col_t2_rd",    32'(rf_rd), 32'd8);
    chk32("col_t2_wd",    rf_wd, 32'h0000_00CC);
    chk1 ("col_t2_alurdy", alu_ready, 1'b1);
    cyc();
    chk1 ("col_t3_we_n",  rf_we_n, 1'b1);

    // Load x9 hazard, pending only after push
    ld_issue_valid = 1'b1; ld_issue_rd = 5'd9; rs1 = 5'd9;
    #1;
    chk1 ("x9_issue_cycle", stall, 1'b0);
    cyc();
    ld_issue_valid = 1'b0;
    #1;
    chk1 ("x9_pending", stall, 1'b1);
    rs1 = 5'd0;
    #1;
    chk1 ("rs0_no_stall", stall, 1'b0);
    ld_resp_valid = 1'b1; ld_resp_data = 32'h0000_0099;
    cyc();
    ld_resp_valid = 1'b0;
    #1;
    chk32("x9_rd", 32'(rf_rd), 32'd9);
    // Load to x0: never pending, never written, still pops
    ld_issue_valid = 1'b1; ld_issue_rd = 5'd0;
    cyc();
    ld_issue_valid = 1'b0;
    ld_resp_valid = 1'b1; ld_resp_data = 32'h0000_0077;
    cyc();
    ld_resp_valid = 1'b0;
    #1;
    chk1 ("x0_no_write", rf_we_n, 1'b1);
    chk1 ("x0_no_err",   resp_err, 1'b0);

    // Response with an empty FIFO
    ld_resp_valid = 1'b1; ld_resp_data = 32'h0000_0011;
    cyc();
    ld_resp_valid = 1'b0;
    #1;
    chk1 ("err_set",     resp_err, 1'b1);
    chk1 ("err_no_write", rf_we_n, 1'b1);
    cyc();
    chk1 ("err_sticky",  resp_err, 1'b1);
    // Mid-operation reset discards the outstanding x6 load
    ld_issue_valid = 1'b1; ld_issue_rd = 5'd6;
    cyc();
    ld_issue_valid = 1'b0; rst_n = 1'b0;
    cyc();
    rst_n = 1'b1; rs1 = 5'd6;
    #1;
    chk1 ("mrst_err",   resp_err, 1'b0);
    chk1 ("mrst_we_n",  rf_we_n, 1'b1);
    chk1 ("mrst_stall", stall, 1'b0);
    chk1 ("mrst_ldrdy", ld_issue_ready, 1'b1);
    rs1 = 5'd0;
    ld_resp_valid = 1'b1;
    cyc();
    ld_resp_valid = 1'b0;
    #1;
    chk1 ("mrst_stale_err", resp_err, 1'b1);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    #1;
    chk1 ("rst2_err", resp_err, 1'b0);

    // Simultaneous pop and push of x12 keeps x12 pending
    ld_issue_valid = 1'b1; ld_issue_rd = 5'd12;
    cyc();
    ld_resp_valid = 1'b1; ld_resp_data = 32'h0000_0C0C;
    cyc();
    ld_issue_valid = 1'b0; ld_resp_valid = 1'b0;
    #1;
    chk32("pp_rd", 32'(rf_rd), 32'd12);
    cyc();
    rs1 = 5'd12;
    #1;
    chk1 ("pp_pending", stall, 1'b1);
    rs1 = 5'd0;
    ld_resp_valid = 1'b1;
    cyc();
    ld_resp_valid = 1'b0;
    cyc();
    rs1 = 5'd12;
    #1;
    chk1 ("pp_cleared", stall, 1'b0);
    rs1 = 5'd0;

    // ALU x3 = 0x55 with rs2 = 3 in the write-stage cycle
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h0000_0055;
    cyc();
    alu_valid = 1'b0; rs2 = 5'd3;
    #1;
    chk1 ("ws_we_n", rf_we_n, 1'b0);
    chk1 ("ws_fwd1", rs1_fwd_valid, 1'b0);
`ifdef WB_CTRL_BYPASS_EN
    chk1 ("ws_fwd2_valid", rs2_fwd_valid, 1'b1);
    chk32("ws_fwd2_data",  rs2_fwd_data, 32'h0000_0055);
    chk1 ("ws_stall",      stall, 1'b0);
`else
    chk1 ("ws_fwd2_valid", rs2_fwd_valid, 1'b0);
    chk32("ws_fwd2_data",  rs2_fwd_data, 32'd0);
    chk1 ("ws_stall",      stall, 1'b1);
`endif
    rs2 = 5'd0;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
